// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined approximate unsigned multiplier built from 4x4 tiles.
// Low-significance tiles may be truncated per transaction; valid/ready stream I/O.
module approx_mult_pipe #(
    parameter int WIDTH      = 8,
    parameter int TRUNC_BITS = 2,
    parameter int APPROX_SIG = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] R
);

    localparam int D  = WIDTH / 4;
    localparam int NT = D * D;
    localparam int PW = 2 * WIDTH;

    localparam logic [7:0] TMASK = 8'hFF << TRUNC_BITS;

    if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 16) begin : g_bad_width
        $error("approx_mult_pipe: WIDTH must be 8, 12 or 16");
    end
    if (TRUNC_BITS < 0 || TRUNC_BITS > 7) begin : g_bad_trunc
        $error("approx_mult_pipe: TRUNC_BITS must be in 0..7");
    end
    if (APPROX_SIG < 0 || APPROX_SIG > 2 * D - 2) begin : g_bad_sig
        $error("approx_mult_pipe: APPROX_SIG must be in 0..2*D-2");
    end

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [NT-1:0][7:0] prod_q, prod_d;
    logic [PW-1:0]     r_q, r_d;

    logic              adv1, adv2;
    logic [7:0]        tile;
    logic [PW-1:0]     sum;

    // Backpressure ripples combinationally from out_ready to in_ready
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        prod_d     = prod_q;
        tile       = '0;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                for (int i = 0; i < D; i++) begin
                    for (int j = 0; j < D; j++) begin
                        tile = 8'(A[4*i +: 4]) * 8'(B[4*j +: 4]);
                        if (mode && (i + j) <= APPROX_SIG) begin
                            tile = tile & TMASK;
                        end
                        prod_d[i*D + j] = tile;
                    end
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                sum = sum + (PW'(prod_q[i*D + j]) << (4 * (i + j)));
            end
        end
    end

    // R keeps its last value across a bubble; only out_valid drops
    always_comb begin
        s2_valid_d = s2_valid_q;
        r_d        = r_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                r_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            r_q        <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            prod_q     <= prod_d;
            r_q        <= r_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign R         = r_q;

endmodule
